// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared FSM encoding and default sizes for the DMA port arbiter
package dma_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RDATA, ST_DONE} arb_state_e;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT = 1024;
  localparam int N_REQ_MAX = 8;
endpackage

// File: rtl/dma_rr_picker.sv
// dma_rr_picker: combinational round-robin select of the next pending client
import dma_arb_pkg::*;
module dma_rr_picker #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int GW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend_i,
  input  logic [GW-1:0]    last_i,
  output logic [GW-1:0]    grant_o,
  output logic             any_o
);
  logic [GW-1:0] idx;
  // Scan starting just after the last grant so every pending client gets its turn.
  always_comb begin
    grant_o = '0;
    any_o = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = GW'((int'(last_i) + k) % N_REQ);
      if (!any_o && pend_i[idx]) begin
        grant_o = idx;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: round-robin share of one Avalon-MM master among pulse-protocol clients (watchdog under DMA_ARB_TIMEOUT_EN)
import dma_arb_pkg::*;
module dma_port_arbiter #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_read,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_writedata,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [DATA_W-1:0]       req_readdata,
  output logic [N_REQ-1:0]        req_busy,
  output logic [N_REQ-1:0]        req_err,
  output logic [ADDR_W-1:0]       m_addr,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_W-1:0]       m_writedata,
  input  logic [DATA_W-1:0]       m_readdata,
  input  logic                    m_waitrequest,
  input  logic                    m_readdatavalid
);
  localparam int GW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > N_REQ_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dma_port_arbiter: unsupported configuration");
  end
  arb_state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic any, done;
  logic [N_REQ-1:0] pend_q, pend_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q [N_REQ];
  logic [ADDR_W-1:0] addr_d [N_REQ];
  logic [DATA_W-1:0] data_q [N_REQ];
  logic [DATA_W-1:0] data_d [N_REQ];
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic m_read_q, m_read_d, m_write_q, m_write_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, rdata_q, rdata_d;
`ifdef DMA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic expired;
  assign expired = tmo_q == TW'(TIMEOUT_CYCLES - 1) &&
                   ((state_q == ST_REQ && m_waitrequest) || (state_q == ST_RDATA && !m_readdatavalid));
`endif
  dma_rr_picker #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .pend_i(pend_q), .last_i(last_q), .grant_o(pick), .any_o(any)
  );
  assign done = state_q == ST_DONE;
  assign req_rdy = done ? N_REQ'(1) << grant_q : '0;
  assign req_readdata = done ? rdata_q : '0;
  assign req_busy = pend_q;
  assign req_err = err_q;
  assign m_addr = m_addr_q;
  assign m_read = m_read_q;
  assign m_write = m_write_q;
  assign m_writedata = m_wdata_q;
  // Bus FSM plus strobe capture; capture runs last so a new strobe beats the DONE clear.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    pend_d = pend_q;
    we_d = we_q;
    err_d = err_q;
    addr_d = addr_q;
    data_d = data_q;
    m_addr_d = m_addr_q;
    m_read_d = m_read_q;
    m_write_d = m_write_q;
    m_wdata_d = m_wdata_q;
    rdata_d = rdata_q;
`ifdef DMA_ARB_TIMEOUT_EN
    tmo_d = (state_q == ST_REQ || state_q == ST_RDATA) ? tmo_q + 1'b1 : '0;
`endif
    case (state_q)
      ST_IDLE: if (any) begin
        grant_d = pick;
        m_addr_d = addr_q[pick];
        m_wdata_d = data_q[pick];
        m_write_d = we_q[pick];
        m_read_d = !we_q[pick];
        state_d = ST_REQ;
      end
      ST_REQ: if (!m_waitrequest) begin
        m_read_d = 1'b0;
        m_write_d = 1'b0;
        state_d = m_write_q ? ST_DONE : ST_RDATA;
      end
      ST_RDATA: if (m_readdatavalid) begin
        rdata_d = m_readdata;
        state_d = ST_DONE;
      end
      default: begin
        pend_d[grant_q] = 1'b0;
        last_d = grant_q;
        state_d = ST_IDLE;
      end
    endcase
`ifdef DMA_ARB_TIMEOUT_EN
    if (expired) begin
      m_read_d = 1'b0;
      m_write_d = 1'b0;
      err_d[grant_q] = 1'b1;
      rdata_d = '0;
      state_d = ST_DONE;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (req_read[i] || req_write[i]) begin
        if (!pend_q[i] || (done && grant_q == GW'(i))) begin
          pend_d[i] = 1'b1;
          we_d[i] = req_write[i];
          addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
          data_d[i] = req_writedata[i*DATA_W +: DATA_W];
        end else begin
          err_d[i] = 1'b1;
        end
      end
    end
  end
  // Control and bus registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q <= GW'(N_REQ - 1);
      pend_q <= '0;
      we_q <= '0;
      err_q <= '0;
      m_addr_q <= '0;
      m_read_q <= 1'b0;
      m_write_q <= 1'b0;
      m_wdata_q <= '0;
      rdata_q <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      pend_q <= pend_d;
      we_q <= we_d;
      err_q <= err_d;
      m_addr_q <= m_addr_d;
      m_read_q <= m_read_d;
      m_write_q <= m_write_d;
      m_wdata_q <= m_wdata_d;
      rdata_q <= rdata_d;
`ifdef DMA_ARB_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  // Command slots are plain storage, only meaningful while their pend bit is set.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_dma_port_arbiter.sv
// tb_dma_port_arbiter: directed self-checking bench for dma_port_arbiter
module tb_dma_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_read, req_write, req_rdy, req_busy, req_err;
  logic [127:0] req_addr, req_writedata;
  logic [31:0] req_readdata, m_addr, m_writedata, m_readdata;
  logic m_read, m_write, m_waitrequest, m_readdatavalid;
  int total = 0;
  int passed = 0;

  dma_port_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_writedata(req_writedata), .req_rdy(req_rdy), .req_readdata(req_readdata),
    .req_busy(req_busy), .req_err(req_err), .m_addr(m_addr), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input int c, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (wr) req_write[c] = 1'b1;
    else req_read[c] = 1'b1;
    req_addr[c*32 +: 32] = a;
    req_writedata[c*32 +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    req_addr = '0;
    req_writedata = '0;
    m_readdata = '0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    total++; if ({m_read, m_write} !== 2'b00) $display("FAIL reset_rw: got %b want 00", {m_read, m_write}); else passed++;
    total++; if (m_addr !== 32'h0 || m_writedata !== 32'h0) $display("FAIL reset_bus: got %h/%h want 0/0", m_addr, m_writedata); else passed++;
    total++; if ({req_rdy, req_busy, req_err} !== 12'h0) $display("FAIL reset_req: got %h want 000", {req_rdy, req_busy, req_err}); else passed++;
    total++; if (req_readdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", req_readdata); else passed++;
  endtask

  task automatic test_single_write;
    strobe(0, 1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    req_write = '0;
    total++; if (req_busy !== 4'b0001 || m_write !== 1'b0) $display("FAIL t1_pend: busy %b m_write %b want 0001/0", req_busy, m_write); else passed++;
    tick();
    total++; if ({m_write, m_read} !== 2'b10) $display("FAIL t1_wr: got %b want 10", {m_write, m_read}); else passed++;
    total++; if (m_addr !== 32'h100 || m_writedata !== 32'hDEADBEEF) $display("FAIL t1_bus: got %h/%h want 100/deadbeef", m_addr, m_writedata); else passed++;
    tick();
    total++; if (req_rdy !== 4'b0001 || m_write !== 1'b0) $display("FAIL t1_rdy: rdy %b m_write %b want 0001/0", req_rdy, m_write); else passed++;
    tick();
    total++; if (req_busy !== 4'b0000 || req_rdy !== 4'b0000) $display("FAIL t1_idle: busy %b rdy %b want 0000/0000", req_busy, req_rdy); else passed++;
  endtask

  task automatic test_read_wait;
    int stable;
    stable = 0;
    m_waitrequest = 1'b1;
    strobe(2, 1'b0, 32'h40, 32'h0);
    tick();
    req_read = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) m_waitrequest = 1'b0;
      if (m_read && !m_write && m_addr == 32'h40) stable++;
    end
    total++; if (stable !== 4) $display("FAIL t2_read_stable: got %0d cycles want 4", stable); else passed++;
    tick();
    total++; if (m_read !== 1'b0 || req_rdy !== 4'b0) $display("FAIL t2_rdata: m_read %b rdy %b want 0/0000", m_read, req_rdy); else passed++;
    tick();
    m_readdatavalid = 1'b1;
    m_readdata = 32'h1234;
    total++; if (req_rdy !== 4'b0) $display("FAIL t2_early: rdy %b want 0000", req_rdy); else passed++;
    tick();
    m_readdatavalid = 1'b0;
    m_readdata = 32'hFFFF_FFFF;
    total++; if (req_rdy !== 4'b0100) $display("FAIL t2_rdy: got %b want 0100", req_rdy); else passed++;
    total++; if (req_readdata !== 32'h1234) $display("FAIL t2_data: got %h want 00001234", req_readdata); else passed++;
    tick();
    total++; if (req_rdy !== 4'b0 || req_busy !== 4'b0) $display("FAIL t2_after: rdy %b busy %b want 0000/0000", req_rdy, req_busy); else passed++;
  endtask

  task automatic test_round_robin;
    int ord [8];
    logic [31:0] dat [8];
    int n;
    bit again;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_dat [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0};
    n = 0;
    again = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) strobe(i, 1'b1, 32'h1000 + 32'(i * 16), 32'hA0 + 32'(i));
    for (int k = 0; k < 30; k++) begin
      tick();
      req_write = '0;
      if (m_write && !m_waitrequest && n < 8) begin
        ord[n] = int'(m_addr[7:4]);
        dat[n] = m_writedata;
        n++;
      end
      if (req_rdy[0] && !again) begin
        again = 1'b1;
        strobe(0, 1'b1, 32'h1000, 32'hB0);
      end
    end
    total++; if (n !== 5) $display("FAIL t3_count: got %0d want 5", n); else passed++;
    for (int k = 0; k < 5; k++) begin
      total++; if (k < n && (ord[k] !== exp_ord[k] || dat[k] !== exp_dat[k])) $display("FAIL t3_order%0d: client %0d data %h want %0d/%h", k, ord[k], dat[k], exp_ord[k], exp_dat[k]); else if (k < n) passed++; else $display("FAIL t3_order%0d: missing want %0d", k, exp_ord[k]);
    end
    total++; if (req_err !== 4'b0 || req_busy !== 4'b0) $display("FAIL t3_end: err %b busy %b want 0000/0000", req_err, req_busy); else passed++;
  endtask

  task automatic test_dropped_strobe;
    int n;
    logic [31:0] a;
    n = 0;
    a = '0;
    strobe(1, 1'b1, 32'h200, 32'h11);
    for (int k = 0; k < 10; k++) begin
      tick();
      req_write = '0;
      if (k == 1) strobe(1, 1'b1, 32'h300, 32'h22);
      if (m_write && !m_waitrequest) begin
        n++;
        a = m_addr;
      end
    end
    total++; if (n !== 1) $display("FAIL t4_count: got %0d want 1", n); else passed++;
    total++; if (a !== 32'h200) $display("FAIL t4_addr: got %h want 00000200", a); else passed++;
    total++; if (req_err !== 4'b0010) $display("FAIL t4_err: got %b want 0010", req_err); else passed++;
    total++; if (req_busy !== 4'b0) $display("FAIL t4_busy: got %b want 0000", req_busy); else passed++;
  endtask

  task automatic test_reset_in_flight;
    bit seen;
    seen = 1'b0;
    strobe(3, 1'b0, 32'h500, 32'h0);
    tick();
    req_read = '0;
    tick();
    total++; if (m_read !== 1'b1 || m_addr !== 32'h500) $display("FAIL t5_req: m_read %b addr %h want 1/500", m_read, m_addr); else passed++;
    tick();
    total++; if (m_read !== 1'b0 || req_busy !== 4'b1000) $display("FAIL t5_rdata: m_read %b busy %b want 0/1000", m_read, req_busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_readdatavalid = 1'b1;
    m_readdata = 32'hBAD;
    total++; if ({req_rdy, req_busy, req_err} !== 12'h0) $display("FAIL t5_clear: got %h want 000", {req_rdy, req_busy, req_err}); else passed++;
    total++; if ({m_read, m_write} !== 2'b00 || m_addr !== 32'h0) $display("FAIL t5_bus: rw %b addr %h want 00/0", {m_read, m_write}, m_addr); else passed++;
    for (int k = 0; k < 5; k++) begin
      tick();
      m_readdatavalid = 1'b0;
      if (req_rdy !== 4'b0 || m_read || m_write) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL t5_stray: got activity %b want 0", seen); else passed++;
  endtask

  task automatic test_stuck_waitrequest;
    int cnt;
    cnt = 0;
    m_waitrequest = 1'b1;
    strobe(0, 1'b1, 32'h600, 32'h60);
    strobe(1, 1'b1, 32'h610, 32'h61);
    tick();
    req_write = '0;
`ifdef DMA_ARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!m_write) break;
      cnt++;
    end
    total++; if (cnt !== 8) $display("FAIL t6_hold: got %0d cycles want 8", cnt); else passed++;
    total++; if (req_rdy !== 4'b0001 || req_readdata !== 32'h0) $display("FAIL t6_rdy: rdy %b data %h want 0001/0", req_rdy, req_readdata); else passed++;
    total++; if (req_err !== 4'b0001) $display("FAIL t6_err: got %b want 0001", req_err); else passed++;
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      if (m_write && m_addr == 32'h600) cnt++;
    end
    total++; if (cnt !== 30) $display("FAIL t6_hold: got %0d cycles want 30", cnt); else passed++;
    total++; if (req_rdy !== 4'b0 || req_err !== 4'b0) $display("FAIL t6_wait: rdy %b err %b want 0000/0000", req_rdy, req_err); else passed++;
    m_waitrequest = 1'b0;
    tick();
    total++; if (req_rdy !== 4'b0001) $display("FAIL t6_rdy: got %b want 0001", req_rdy); else passed++;
`endif
    m_waitrequest = 1'b0;
    tick();
    tick();
    total++; if (m_write !== 1'b1 || m_addr !== 32'h610 || m_writedata !== 32'h61) $display("FAIL t6_next: wr %b addr %h data %h want 1/610/61", m_write, m_addr, m_writedata); else passed++;
    tick();
    total++; if (req_rdy !== 4'b0010) $display("FAIL t6_next_rdy: got %b want 0010", req_rdy); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_dropped_strobe();
    test_reset_in_flight();
    test_stuck_waitrequest();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
